// File: rtl/mem_request.sv
// Single-port RAM arbiter: alternates instruction fetch and data access for a single-cycle core.
// Holds the fetched instruction and the load data in registers for the core.
module mem_request (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        busy_o,
  input  logic [31:0] imemaddr,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [31:0] ramload,
  input  logic [5:0]  cuOP,
  output logic        Ren,
  output logic        Wen,
  output logic [31:0] imemload,
  output logic [31:0] dmmload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);

  typedef enum logic {FETCH, DATA} state_t;

  state_t state, state_next;
  logic   is_load, is_store;

  assign is_load  = (cuOP >= 6'd10) && (cuOP <= 6'd14);
  assign is_store = (cuOP >= 6'd15) && (cuOP <= 6'd17);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      imemload <= '0;
      dmmload  <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && !busy_o)
        imemload <= ramload;
      if (state == DATA && is_load && !busy_o)
        dmmload <= ramload;
    end
  end

  // A non-memory op still spends one DATA cycle, then falls back to FETCH.
  always_comb begin
    state_next = state;
    Ren        = 1'b0;
    Wen        = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    case (state)
      FETCH: begin
        Ren     = 1'b1;
        ramaddr = imemaddr;
        if (!busy_o)
          state_next = DATA;
      end
      DATA: begin
        if (is_load) begin
          Ren     = 1'b1;
          ramaddr = dmmaddr;
          if (!busy_o)
            state_next = FETCH;
        end else if (is_store) begin
          Wen      = 1'b1;
          ramaddr  = dmmaddr;
          ramstore = dmmstore;
          if (!busy_o)
            state_next = FETCH;
        end else begin
          ramaddr    = imemaddr;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
    // The RAM port is quiet for as long as reset is held.
    if (!nRST) begin
      Ren      = 1'b0;
      Wen      = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
    end
  end

endmodule

// File: tb/tb_mem_request.sv
// Scoreboard bench for mem_request: expectations are queued as stimulus is driven
// and drained against the DUT outputs half a cycle after each edge.
module tb_mem_request;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        busy_o;
  logic [31:0] imemaddr, dmmaddr, dmmstore, ramload;
  logic [5:0]  cuOP;
  logic        Ren, Wen;
  logic [31:0] imemload, dmmload, ramaddr, ramstore;

  int n_checks = 0;
  int n_bad    = 0;

  logic [31:0] m_imem, m_dmm;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  mem_request dut (
    .CLK(CLK), .nRST(nRST), .busy_o(busy_o), .imemaddr(imemaddr),
    .dmmaddr(dmmaddr), .dmmstore(dmmstore), .ramload(ramload), .cuOP(cuOP),
    .Ren(Ren), .Wen(Wen), .imemload(imemload), .dmmload(dmmload),
    .ramaddr(ramaddr), .ramstore(ramstore)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic push_bus(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] s);
    push({tag, ".Ren"}, 0, {31'b0, r});
    push({tag, ".Wen"}, 1, {31'b0, w});
    push({tag, ".ramaddr"}, 2, a);
    push({tag, ".ramstore"}, 3, s);
  endtask

  task automatic push_regs(input string tag);
    push({tag, ".imemload"}, 4, m_imem);
    push({tag, ".dmmload"}, 5, m_dmm);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = {31'b0, Ren};
        1:       obs = {31'b0, Wen};
        2:       obs = ramaddr;
        3:       obs = ramstore;
        4:       obs = imemload;
        default: obs = dmmload;
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // Called at a negedge while in FETCH; returns at the negedge after completion (DATA).
  task automatic do_fetch(input string tag, input logic [31:0] addr,
                          input logic [31:0] instr, input int nbusy);
    imemaddr = addr;
    ramload  = instr;
    for (int i = 0; i < nbusy; i++) begin
      busy_o = 1'b1;
      #1;
      push_bus({tag, ".fbusy"}, 1'b1, 1'b0, addr, 32'h0);
      push_regs({tag, ".fbusy"});
      drain();
      @(negedge CLK);
    end
    busy_o = 1'b0;
    #1;
    push_bus({tag, ".fdone"}, 1'b1, 1'b0, addr, 32'h0);
    drain();
    @(negedge CLK);
    m_imem = instr;
    push_regs({tag, ".fetched"});
    drain();
  endtask

  // Called at a negedge in DATA; returns at the negedge back in FETCH.
  task automatic do_data(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int nbusy);
    logic ld, st;
    ld = (op >= 6'd10 && op <= 6'd14);
    st = (op >= 6'd15 && op <= 6'd17);
    cuOP     = op;
    dmmaddr  = addr;
    dmmstore = sdata;
    ramload  = rdata;
    if (!ld && !st) begin
      busy_o = (nbusy > 0);
      #1;
      push_bus({tag, ".pass"}, 1'b0, 1'b0, imemaddr, 32'h0);
      drain();
      @(negedge CLK);
    end else begin
      for (int i = 0; i < nbusy; i++) begin
        busy_o = 1'b1;
        #1;
        push_bus({tag, ".dbusy"}, ld, st, addr, st ? sdata : 32'h0);
        push_regs({tag, ".dbusy"});
        drain();
        @(negedge CLK);
      end
      busy_o = 1'b0;
      #1;
      push_bus({tag, ".ddone"}, ld, st, addr, st ? sdata : 32'h0);
      drain();
      @(negedge CLK);
      if (ld) m_dmm = rdata;
    end
    busy_o = 1'b1;
    #1;
    push_bus({tag, ".back"}, 1'b1, 1'b0, imemaddr, 32'h0);
    push_regs({tag, ".back"});
    drain();
  endtask

  initial begin
    nRST = 1'b0; busy_o = 1'b0; cuOP = 6'd10;
    imemaddr = 32'h1111_1111; dmmaddr = 32'h2222_2222;
    dmmstore = 32'h3333_3333; ramload = 32'h4444_4444;
    m_imem = 32'h0; m_dmm = 32'h0;
    repeat (3) @(negedge CLK);
    #1;
    push_bus("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    push_regs("reset");
    drain();

    @(negedge CLK);
    nRST = 1'b1;
    do_fetch("fetch", 32'hABCD_ABCD, 32'h1234_1234, 2);
    do_data("load", 6'd10, 32'h5678_5678, 32'h0, 32'h4321_4321, 2);

    do_fetch("fetch2", 32'h0000_0100, 32'h00A0_2023, 0);
    do_data("store", 6'd17, 32'hABCD_ABCD, 32'h3333_3333, 32'hDEAD_BEEF, 1);

    do_fetch("fetch3", 32'h0000_0104, 32'h0020_81B3, 1);
    do_data("nonmem", 6'd28, 32'h0BAD_0BAD, 32'h5555_5555, 32'h7777_7777, 1);

    // Reset asserted mid-way through a load that is still busy.
    do_fetch("fetch4", 32'h0000_0108, 32'h0000_A103, 0);
    cuOP = 6'd10; dmmaddr = 32'h0000_4000; ramload = 32'h9999_9999; busy_o = 1'b1;
    #1;
    push_bus("midrst.pre", 1'b1, 1'b0, 32'h0000_4000, 32'h0);
    drain();
    #2;
    nRST = 1'b0;
    #1;
    m_imem = 32'h0; m_dmm = 32'h0;
    push_bus("midrst.asserted", 1'b0, 1'b0, 32'h0, 32'h0);
    push_regs("midrst.asserted");
    drain();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    push_bus("midrst.release", 1'b1, 1'b0, imemaddr, 32'h0);
    drain();
    do_fetch("fetch5", 32'h0000_0200, 32'hCAFE_F00D, 1);
    do_data("load2", 6'd14, 32'h0000_0300, 32'h0, 32'h0000_BEEF, 0);

    for (int i = 0; i < 16; i++) begin
      do_fetch("rnd.f", $urandom, $urandom, $urandom_range(0, 2));
      do_data("rnd.d", 6'($urandom_range(0, 38)), $urandom, $urandom, $urandom,
              $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_request.md
# mem_request

Single-port memory request arbiter between the single-cycle RISC-V core and a shared RAM. It alternates an instruction-fetch phase and, for load/store instructions, a data-access phase on one RAM port. It drives RAM address, read/write enables and store data, and holds the returned instruction and load data in registers for the core.

## Interface
Parameters: none. Widths are fixed at 32-bit data/address and a 6-bit opcode.

- `CLK`  in  1  system clock, rising-edge active
- `nRST`  in  1  reset, asynchronous, active-low
- `busy_o`  in  1  RAM busy. 1 = access in progress. 0 = access done; read data on `ramload` is valid this cycle.
- `imemaddr`  in  32  instruction fetch address (PC)
- `dmmaddr`  in  32  data access address
- `dmmstore`  in  32  store data
- `ramload`  in  32  RAM read data
- `cuOP`  in  6  decoded op, `cuOPType` encoding: LUI=0, AUIPC=1, JAL=2, JALR=3, BEQ..BGEU=4..9, LB=10, LH=11, LW=12, LBU=13, LHU=14, SB=15, SH=16, SW=17, I-type ALU=18..27, R-type=28..37, ERROR=38
- `Ren`  out  1  RAM read enable
- `Wen`  out  1  RAM write enable
- `imemload`  out  32  registered fetched instruction
- `dmmload`  out  32  registered load data
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data

## Operation
- `is_load` = `cuOP` in 10..14. `is_store` = `cuOP` in 15..17.
- Two-state FSM. Reset state is FETCH.
- **FETCH state**
  - Outputs: `Ren`=1, `Wen`=0, `ramaddr`=`imemaddr`, `ramstore`=0.
  - When `busy_o`=0: at the clock edge, `imemload` <= `ramload`.
  - Next state is DATA if the post-update `cuOP` (decoded from the new instruction, evaluated in the following cycle) is a load or store.
  - Implementation: always go to DATA; DATA with a non-memory `cuOP` exits immediately (see below).
- **DATA state**
  - If `is_load`: `Ren`=1, `Wen`=0, `ramaddr`=`dmmaddr`, `ramstore`=0.
  - If `is_store`: `Ren`=0, `Wen`=1, `ramaddr`=`dmmaddr`, `ramstore`=`dmmstore`.
  - Otherwise: `Ren`=`Wen`=0, `ramaddr`=`imemaddr`, `ramstore`=0, and the FSM returns to FETCH on the next edge regardless of `busy_o`.
  - For a load or store, when `busy_o`=0 the FSM goes to FETCH at the edge. A load also captures `dmmload` <= `ramload` at that edge; a store leaves `dmmload` unchanged.
- While `busy_o`=1 the state holds and all outputs hold their state-derived values. `imemload`/`dmmload` do not change.
- `Ren` and `Wen` are never both 1.

## Timing
- `Ren`, `Wen`, `ramaddr`, `ramstore` are combinational from state, `cuOP`, and the address/data inputs.
- `imemload`, `dmmload` and state are registered.
- Latency: an access completes on the first rising edge with `busy_o`=0. Minimum 1 cycle per phase.
  - Load/store instruction: at least 2 cycles total.
  - Other instruction: 1 fetch cycle + 1 pass-through DATA cycle.
- `busy_o`=0 in the very first cycle of a phase is legal; that phase completes at the next edge.
- Reset (`nRST`=0, any time including mid-access):
  - Immediately: state=FETCH, `imemload`=0, `dmmload`=0.
  - While `nRST`=0, `Ren`, `Wen`, `ramaddr`, `ramstore` are forced to 0.
  - The first cycle after release is a FETCH of `imemaddr`.
- `cuOP` changes while in DATA with `busy_o`=1 take effect combinationally. The core must keep `cuOP` stable during an access.

## Test plan
- **Reset:** hold `nRST`=0 with `busy_o`=0, `cuOP`=LB -> `Ren`=`Wen`=0, `ramaddr`=0, `ramstore`=0, `imemload`=`dmmload`=0.
- **Fetch:** release reset, `busy_o`=1, `imemaddr`=0xABCDABCD, `ramload`=0x12341234 -> `Ren`=1, `ramaddr`=0xABCDABCD, `imemload` stays 0. Drop `busy_o` -> next edge `imemload`=0x12341234, state DATA.
- **Load:** `cuOP`=LB, `dmmaddr`=0x56785678, `ramload`=0x43214321, `busy_o`=1 -> `Ren`=1, `ramaddr`=0x56785678. Drop `busy_o` -> `dmmload`=0x43214321, state FETCH.
- **Store:** `cuOP`=SW, `dmmaddr`=0xABCDABCD, `dmmstore`=0x33333333 in DATA -> `Wen`=1, `Ren`=0, `ramaddr`=0xABCDABCD, `ramstore`=0x33333333. On completion `dmmload` is unchanged.
- **Non-memory op:** `cuOP`=ADD (28) after a fetch -> one DATA cycle with `Ren`=`Wen`=0, then FETCH of the next `imemaddr`. `dmmload` is unchanged.
- **Reset mid-access:** assert `nRST` during a DATA load with `busy_o`=1 -> outputs 0 immediately. After release the first access is a FETCH.
